// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the CU program sequencer: instruction classes,
// sequencer state encoding and default hold lengths.
package instr_sequencer_pkg;

    // Instruction class field values (top two bits of every word)
    typedef enum logic [1:0] {
        CLS_HALT  = 2'b00,
        CLS_STD   = 2'b01,
        CLS_LOAD  = 2'b10,
        CLS_STORE = 2'b11
    } instr_cls_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_e;

    localparam int unsigned DEF_INSTR_WIDTH = 20;
    localparam int unsigned DEF_PC_BITS     = 5;
    localparam int unsigned DEF_STD_CYC     = 3;
    localparam int unsigned DEF_LOAD_CYC    = 4;
    localparam int unsigned DEF_STORE_CYC   = 3;

endpackage

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches words from a synchronous instruction ROM and holds
// each on `instr` for the number of cycles its class occupies in the CU FSM.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int unsigned PC_BITS     = DEF_PC_BITS,
    parameter int unsigned STD_CYC     = DEF_STD_CYC,
    parameter int unsigned LOAD_CYC    = DEF_LOAD_CYC,
    parameter int unsigned STORE_CYC   = DEF_STORE_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall,
    output logic                   imem_en,
    output logic [PC_BITS-1:0]     imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   halted
);

    localparam int unsigned MAX_CYC =
        (STD_CYC >= LOAD_CYC) ? ((STD_CYC >= STORE_CYC) ? STD_CYC : STORE_CYC)
                              : ((LOAD_CYC >= STORE_CYC) ? LOAD_CYC : STORE_CYC);
    localparam int unsigned CNT_W = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    // Remaining hold cycles after the first, per instruction class
    function automatic logic [CNT_W-1:0] hold_cnt(input instr_cls_e cls);
        case (cls)
            CLS_STD:   return CNT_W'(STD_CYC - 1);
            CLS_LOAD:  return CNT_W'(LOAD_CYC - 1);
            CLS_STORE: return CNT_W'(STORE_CYC - 1);
            default:   return '0;
        endcase
    endfunction

    seq_state_e             state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [PC_BITS-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   halted_q, halted_d;
    instr_cls_e             cls;

    assign cls = instr_cls_e'(imem_data[INSTR_WIDTH-1 -: 2]);

    // Next-state, PC, counter and registered-output decode
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                    addr_d  = '0;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                instr_d = imem_data;
                if (cls == CLS_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = hold_cnt(cls);
                end
            end
            ST_HOLD: begin
                // stall freezes the countdown even when it has reached zero
                if (!stall) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pc_d    = pc_q + PC_BITS'(1);
                        addr_d  = pc_q + PC_BITS'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        en_d     = (state_d == ST_FETCH);
        valid_d  = (state_d == ST_HOLD);
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_LOAD) || (state_d == ST_HOLD);
        halted_d = (state_d == ST_HALT);
    end

    // State, PC, counter and output registers; reset aborts any instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign imem_en     = en_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: synchronous ROM model, behavioural reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_instr_sequencer;

    localparam int unsigned IW = 20;
    localparam int unsigned PB = 5;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stall;
    logic          imem_en;
    logic [PB-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [PB-1:0] pc;
    logic          busy;
    logic          halted;

    int vectors = 0;
    int errors  = 0;
    logic chk_en = 1'b0;

    logic [IW-1:0] rom [32];
    logic [IW-1:0] rom_q = '0;

    instr_sequencer #(
        .INSTR_WIDTH(IW), .PC_BITS(PB), .STD_CYC(3), .LOAD_CYC(4), .STORE_CYC(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .busy(busy), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data appears one cycle after imem_en
    always @(posedge clk) if (imem_en) rom_q <= rom[imem_addr];
    assign imem_data = rom_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 fetching, 2 loading, 3 presenting, 4 halted
    int            m_ph;
    logic [PB-1:0] m_pc;
    logic [IW-1:0] m_instr;
    int            m_done;
    int            m_need;

    function automatic int need_of(input logic [1:0] c);
        case (c)
            2'b01:   return 3;
            2'b10:   return 4;
            2'b11:   return 3;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ph <= 0; m_pc <= '0; m_instr <= '0; m_done <= 0; m_need <= 0;
        end else begin
            case (m_ph)
                0, 4: if (start) begin m_ph <= 1; m_pc <= '0; end
                1: m_ph <= 2;
                2: begin
                    m_instr <= rom[m_pc];
                    if (rom[m_pc][19:18] == 2'b00) m_ph <= 4;
                    else begin
                        m_ph   <= 3;
                        m_done <= 1;
                        m_need <= need_of(rom[m_pc][19:18]);
                    end
                end
                3: if (!stall) begin
                    if (m_done >= m_need) begin m_ph <= 1; m_pc <= m_pc + 5'd1; end
                    else m_done <= m_done + 1;
                end
                default: m_ph <= 0;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_en",     32'(imem_en),     32'(m_ph == 1));
            check("imem_addr",   32'(imem_addr),   32'(m_pc));
            check("instr",       32'(instr),       32'(m_instr));
            check("instr_valid", 32'(instr_valid), 32'(m_ph == 3));
            check("pc",          32'(pc),          32'(m_pc));
            check("busy",        32'(busy),        32'(m_ph >= 1 && m_ph <= 3));
            check("halted",      32'(halted),      32'(m_ph == 4));
        end
    end

    // ---------------- directed helpers ----------------
    logic          tv[$];
    logic [PB-1:0] tp[$];
    logic [IW-1:0] ti[$];
    logic          th[$];
    int            runs[$];
    int            lead;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic record();
        tv.push_back(instr_valid);
        tp.push_back(pc);
        ti.push_back(instr);
        th.push_back(halted);
    endtask

    task automatic clear_trace();
        tv.delete(); tp.delete(); ti.delete(); th.delete();
    endtask

    // Run lengths of instr_valid after the leading zeros: 1s, 0s, 1s, ...
    task automatic analyze();
        int i;
        int len;
        logic cur;
        runs.delete();
        lead = 0;
        i = 0;
        while (i < tv.size() && tv[i] == 1'b0) begin lead++; i++; end
        while (i < tv.size()) begin
            cur = tv[i];
            len = 0;
            while (i < tv.size() && tv[i] == cur) begin len++; i++; end
            runs.push_back(len);
        end
        while (runs.size() < 4) runs.push_back(0);
    endtask

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        for (int k = 0; k < 32; k++) rom[k] = '0;
        #2 rst = 1'b0;
        #10 rst = 1'b1;
        chk_en = 1'b1;
        tick();

        // 1: reset asserted mid-hold (one cycle before the last hold cycle)
        rom[0] = 20'h4_1230; rom[1] = 20'h0_0000;
        pulse_start();
        tick(); tick(); tick();
        check("t1_mid_hold_valid", 32'(instr_valid), 32'd1);
        rst = 1'b0;
        #2;
        check("t1_rst_imem_en",   32'(imem_en),     32'd0);
        check("t1_rst_imem_addr", 32'(imem_addr),   32'd0);
        check("t1_rst_instr",     32'(instr),       32'd0);
        check("t1_rst_valid",     32'(instr_valid), 32'd0);
        check("t1_rst_pc",        32'(pc),          32'd0);
        check("t1_rst_busy",      32'(busy),        32'd0);
        check("t1_rst_halted",    32'(halted),      32'd0);
        #1 rst = 1'b1;
        repeat (4) tick();
        check("t1_idle_busy",   32'(busy),    32'd0);
        check("t1_idle_en",     32'(imem_en), 32'd0);
        check("t1_idle_halted", 32'(halted),  32'd0);

        // 2: single std word then halt
        pulse_start();
        clear_trace();
        repeat (8) begin tick(); record(); end
        analyze();
        check("t2_first_valid_clock", 32'(lead + 2), 32'd3);
        check("t2_valid_len",         32'(runs[0]),  32'd3);
        check("t2_instr",             32'(ti[1]),    32'h41230);
        check("t2_pc_during",         32'(tp[1]),    32'd0);
        check("t2_halted",            32'(th[7]),    32'd1);
        check("t2_pc_halt",           32'(tp[7]),    32'd1);

        // 3: loadR, storeR, halt
        rom[0] = 20'h8_0ABC; rom[1] = 20'hC_0DEF; rom[2] = 20'h0_0000;
        pulse_start();
        clear_trace();
        repeat (16) begin tick(); record(); end
        analyze();
        check("t3_load_len",  32'(runs[0]), 32'd4);
        check("t3_gap_len",   32'(runs[1]), 32'd2);
        check("t3_store_len", 32'(runs[2]), 32'd3);
        check("t3_pc0",       32'(tp[1]),   32'd0);
        check("t3_instr0",    32'(ti[1]),   32'h80ABC);
        check("t3_pc1",       32'(tp[7]),   32'd1);
        check("t3_instr1",    32'(ti[7]),   32'hC0DEF);
        check("t3_pc2",       32'(tp[15]),  32'd2);
        check("t3_halted",    32'(th[15]),  32'd1);

        // 4: five stall cycles in the middle of a std hold
        rom[0] = 20'h4_0005; rom[1] = 20'h0_0000;
        pulse_start();
        clear_trace();
        for (int i = 0; i < 16; i++) begin
            stall = (i >= 2 && i < 7);
            tick();
            record();
        end
        stall = 1'b0;
        analyze();
        check("t4_valid_len",    32'(runs[0]), 32'd8);
        check("t4_pc_in_stall",  32'(tp[4]),   32'd0);
        check("t4_instr_stable", 32'(ti[6]),   32'h40005);

        // 5: 32 std words, PC wraps with no halt
        for (int k = 0; k < 32; k++) rom[k] = 20'h4_0000 | 20'(k);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 250 && !found; i++) begin
            tick();
            if (instr_valid && pc == 5'd31) found = 1'b1;
        end
        check("t5_reach_word31", 32'(found), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (imem_en) found = 1'b1;
        end
        check("t5_refetch_seen", 32'(found),     32'd1);
        check("t5_wrap_addr",    32'(imem_addr), 32'd0);
        check("t5_wrap_pc",      32'(pc),        32'd0);
        check("t5_no_halt",      32'(halted),    32'd0);
        tick(); tick();
        check("t5_wrap_instr",   32'(instr),     32'h40000);

        // 6: start during hold is ignored; start in HALT restarts
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        tick();
        rom[0] = 20'h4_0777; rom[1] = 20'h0_0000;
        pulse_start();
        clear_trace();
        for (int i = 0; i < 10; i++) begin
            start = (i == 2);
            tick();
            record();
        end
        start = 1'b0;
        analyze();
        check("t6_hold_len",    32'(runs[0]), 32'd3);
        check("t6_halted",      32'(th[9]),   32'd1);
        check("t6_pc_halt",     32'(tp[9]),   32'd1);
        pulse_start();
        check("t6_restart_en",     32'(imem_en),   32'd1);
        check("t6_restart_addr",   32'(imem_addr), 32'd0);
        check("t6_restart_halted", 32'(halted),    32'd0);
        check("t6_restart_pc",     32'(pc),        32'd0);
        repeat (3) tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
